// File: rtl/led_scan_monitor.sv
// led_scan_monitor
//   Receive side of the row-scanned LED matrix bus. It samples the one-hot row
//   select and the red/green column data, and rebuilds the whole RedPixels/
//   GrnPixels frame in a shadow buffer. It publishes the frame only when every
//   row 0..N-1 has arrived in order.
// Ports
//   clk, rst             clock; asynchronous active-low reset
//   scan_row             row select bus (one-hot when active, all inactive = blank)
//   scan_red, scan_grn   column data for the selected row, bit c = column c
//   err_clr              pulse, clears scan_error
//   RedPixels, GrnPixels last committed frame, [row][col]
//   frame_valid          one-cycle pulse when the frame outputs update
//   frame_count          committed frames, mod 256
//   scan_error           sticky protocol-violation flag
module led_scan_monitor #(
  parameter int N           = 16,
  parameter int MIN_HOLD    = 2,
  parameter int ROW_ACT_LOW = 0,
  parameter int COL_ACT_LOW = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          scan_row,
  input  logic [N-1:0]          scan_red,
  input  logic [N-1:0]          scan_grn,
  input  logic                  err_clr,
  output logic [N-1:0][N-1:0]   RedPixels,
  output logic [N-1:0][N-1:0]   GrnPixels,
  output logic                  frame_valid,
  output logic [7:0]            frame_count,
  output logic                  scan_error
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(MIN_HOLD + 1);
  localparam logic [CW-1:0] HOLD = CW'(MIN_HOLD);

  typedef struct packed {
    logic [N-1:0] row;
    logic [N-1:0] red;
    logic [N-1:0] grn;
  } smp_t;

  typedef enum logic [1:0] {SYNC, CAPTURE, COMMIT} state_t;

  smp_t   smp_d, smp_q, prev_q;
  logic [CW-1:0] cnt_d, cnt_q;
  logic   same, present;

  // A presentation that lands in the COMMIT cycle is parked here.
  // It is replayed on the following cycle.
  logic   pend_d, pend_q;
  smp_t   pend_smp_d, pend_smp_q;

  state_t state_d, state_q;
  logic [IW-1:0] exp_d, exp_q;
  logic [N-1:0][N-1:0] sh_red_d, sh_red_q, sh_grn_d, sh_grn_q;
  logic [N-1:0][N-1:0] red_d, red_q, grn_d, grn_q;
  logic   fv_d, fv_q;
  logic [7:0] fc_d, fc_q;
  logic   err_d, err_q, err_set;

  logic   ev_vld;
  smp_t   ev;
  logic   blank, onehot;
  logic [IW-1:0] k;

  // Normalise bus polarity before the input register.
  always_comb begin
    smp_d.row = (ROW_ACT_LOW != 0) ? ~scan_row : scan_row;
    smp_d.red = (COL_ACT_LOW != 0) ? ~scan_red : scan_red;
    smp_d.grn = (COL_ACT_LOW != 0) ? ~scan_grn : scan_grn;
  end

  // Stability counter. The saturation check makes a held row fire only once.
  // A change always restarts at 1, so MIN_HOLD=1 fires on every change.
  always_comb begin
    same = (smp_q == prev_q);
    if (!same)             cnt_d = CW'(1);
    else if (cnt_q < HOLD) cnt_d = cnt_q + 1'b1;
    else                   cnt_d = cnt_q;
    present = (cnt_d == HOLD) && (!same || (cnt_q != HOLD));
  end

  // Event selection and row classification.
  always_comb begin
    ev_vld     = pend_q | present;
    ev         = pend_q ? pend_smp_q : smp_q;
    pend_d     = 1'b0;
    pend_smp_d = pend_smp_q;
    if (state_q == COMMIT || pend_q) begin
      pend_d     = present;
      pend_smp_d = smp_q;
    end
    blank  = (ev.row == '0);
    onehot = !blank && ((ev.row & (ev.row - 1'b1)) == '0);
    k = '0;
    for (int i = 0; i < N; i++)
      if (ev.row[i]) k = IW'(i);
  end

  always_comb begin
    state_d  = state_q;
    exp_d    = exp_q;
    sh_red_d = sh_red_q;
    sh_grn_d = sh_grn_q;
    red_d    = red_q;
    grn_d    = grn_q;
    fv_d     = 1'b0;
    fc_d     = fc_q;
    err_set  = 1'b0;
    case (state_q)
      SYNC: begin
        if (ev_vld && onehot && k == '0) begin
          sh_red_d[0] = ev.red;
          sh_grn_d[0] = ev.grn;
          exp_d       = IW'(1);
          state_d     = (N == 1) ? COMMIT : CAPTURE;
        end
      end
      CAPTURE: begin
        if (ev_vld && !blank) begin
          if (onehot && k == exp_q) begin
            sh_red_d[k] = ev.red;
            sh_grn_d[k] = ev.grn;
            exp_d       = exp_q + 1'b1;
            if (k == IW'(N - 1)) state_d = COMMIT;
          end else begin
            err_set = 1'b1;
            if (onehot && k == '0) begin
              // A fresh row 0 means the driver restarted.
              // Resynchronise on this row instead of waiting for another row 0.
              sh_red_d[0] = ev.red;
              sh_grn_d[0] = ev.grn;
              exp_d       = IW'(1);
            end else begin
              exp_d   = '0;
              state_d = SYNC;
            end
          end
        end
      end
      COMMIT: begin
        red_d   = sh_red_q;
        grn_d   = sh_grn_q;
        fv_d    = 1'b1;
        fc_d    = fc_q + 8'd1;
        exp_d   = '0;
        state_d = SYNC;
      end
      default: state_d = SYNC;
    endcase
    // A new error takes priority over a clear in the same cycle.
    err_d = err_set | (err_q & ~err_clr);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      smp_q      <= '0;
      prev_q     <= '0;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      pend_smp_q <= '0;
      state_q    <= SYNC;
      exp_q      <= '0;
      sh_red_q   <= '0;
      sh_grn_q   <= '0;
      red_q      <= '0;
      grn_q      <= '0;
      fv_q       <= 1'b0;
      fc_q       <= '0;
      err_q      <= 1'b0;
    end else begin
      smp_q      <= smp_d;
      prev_q     <= smp_q;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      pend_smp_q <= pend_smp_d;
      state_q    <= state_d;
      exp_q      <= exp_d;
      sh_red_q   <= sh_red_d;
      sh_grn_q   <= sh_grn_d;
      red_q      <= red_d;
      grn_q      <= grn_d;
      fv_q       <= fv_d;
      fc_q       <= fc_d;
      err_q      <= err_d;
    end
  end

  assign RedPixels   = red_q;
  assign GrnPixels   = grn_q;
  assign frame_valid = fv_q;
  assign frame_count = fc_q;
  assign scan_error  = err_q;

endmodule
